// File: rtl/shift_register_sipo_rx.sv
// Purpose     : serial-in/parallel-out receiver, assembles WIDTH-bit words from a bit stream.
// Latency     : word visible on par_out/out_valid the cycle after its last bit_valid.
// Backpressure: single-entry holding register; a word completing while it is full and not
//               being drained is dropped, and the sticky overflow flag is set.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   serial_in    serial data bit, only looked at when bit_valid=1
//   bit_valid    serial_in carries a bit this cycle
//   frame_start  abandon the partial word; a same-cycle bit starts the new word
//   par_out      held word (stable while out_valid=1)
//   out_valid    par_out holds an unconsumed word
//   out_ready    downstream takes par_out when out_valid & out_ready
//   bit_count    bits collected in the current partial word (0..WIDTH-1)
//   overflow     sticky: a completed word was dropped due to backpressure
module shift_register_sipo_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       serial_in,
  input  logic                       bit_valid,
  input  logic                       frame_start,
  output logic [WIDTH-1:0]           par_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH+1)-1:0] bit_count,
  output logic                       overflow
);

  localparam int            CW   = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] sr_base;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt_base;
  logic [CW-1:0]    cnt_d;
  logic             complete;
  logic [WIDTH-1:0] par_d;
  logic             vld_d;
  logic             ovf_d;

  // IDLE is simply bit_count==0 and SHIFT is 1..WIDTH-1, so the count itself is the state.
  always_comb begin
    // frame_start wipes the partial word before this cycle's bit is shifted in.
    sr_base  = frame_start ? '0 : sr_q;
    cnt_base = frame_start ? '0 : bit_count;

    if (MSB_FIRST) shifted = {sr_base[WIDTH-2:0], serial_in};
    else           shifted = {serial_in, sr_base[WIDTH-1:1]};

    complete = bit_valid && (cnt_base == LAST);

    sr_d  = sr_base;
    cnt_d = cnt_base;
    if (bit_valid) begin
      if (complete) begin
        sr_d  = '0;
        cnt_d = '0;
      end else begin
        sr_d  = shifted;
        cnt_d = cnt_base + CW'(1);
      end
    end

    par_d = par_out;
    vld_d = out_valid;
    ovf_d = overflow;
    if (complete) begin
      // An empty register, or one drained this same cycle, accepts the new word
      // without a bubble; otherwise the new word is lost.
      if (!out_valid || out_ready) begin
        par_d = shifted;
        vld_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (out_valid && out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q      <= '0;
      bit_count <= '0;
      par_out   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      bit_count <= cnt_d;
      par_out   <= par_d;
      out_valid <= vld_d;
      overflow  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_shift_register_sipo_rx.sv
module tb_shift_register_sipo_rx;

  logic       clk;
  logic       reset;
  logic       serial_in;
  logic       bit_valid;
  logic       frame_start;
  logic       out_ready;

  logic [7:0] par_m, par_l;
  logic       vld_m, vld_l;
  logic       ovf_m, ovf_l;
  logic [3:0] cnt_m, cnt_l;

  int tests = 0;
  int fails = 0;

  // Reference model: pending bits kept in arrival order, words formed arithmetically.
  int         q_bits[$];
  logic [7:0] exp_par_m;
  logic [7:0] exp_par_l;
  logic       exp_vld;
  logic       exp_ovf;

  shift_register_sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .par_out(par_m), .out_valid(vld_m),
    .out_ready(out_ready), .bit_count(cnt_m), .overflow(ovf_m));

  shift_register_sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .par_out(par_l), .out_valid(vld_l),
    .out_ready(out_ready), .bit_count(cnt_l), .overflow(ovf_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic s, input logic bv, input logic fs,
                              input logic rdy, input logic rs);
    int  wm;
    int  wl;
    bit  done;
    wm   = 0;
    wl   = 0;
    done = 1'b0;
    if (rs) begin
      q_bits.delete();
      exp_par_m = 8'h00;
      exp_par_l = 8'h00;
      exp_vld   = 1'b0;
      exp_ovf   = 1'b0;
    end else begin
      if (fs) q_bits.delete();
      if (bv) begin
        q_bits.push_back(int'(s));
        if (q_bits.size() == 8) begin
          // First bit is the MSB in one ordering and the LSB in the other.
          for (int i = 0; i < 8; i++) begin
            wm = wm * 2 + q_bits[i];
            wl = wl + (q_bits[i] << i);
          end
          q_bits.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!exp_vld || rdy) begin
          exp_par_m = 8'(wm);
          exp_par_l = 8'(wl);
          exp_vld   = 1'b1;
        end else begin
          exp_ovf = 1'b1;
        end
      end else if (exp_vld && rdy) begin
        exp_vld = 1'b0;
      end
    end
  endtask

  task automatic step(input logic s, input logic bv, input logic fs,
                      input logic rdy, input logic rs);
    serial_in   = s;
    bit_valid   = bv;
    frame_start = fs;
    out_ready   = rdy;
    reset       = rs;
    @(posedge clk);
    model_update(s, bv, fs, rdy, rs);
    #1;
    check("par_msb", par_m, exp_par_m);
    check("par_lsb", par_l, exp_par_l);
    check("vld_msb", vld_m, exp_vld);
    check("vld_lsb", vld_l, exp_vld);
    check("cnt_msb", cnt_m, q_bits.size());
    check("cnt_lsb", cnt_l, q_bits.size());
    check("ovf_msb", ovf_m, exp_ovf);
    check("ovf_lsb", ovf_l, exp_ovf);
  endtask

  // Sends a word first-bit = w[7]; optional random gaps with serial_in toggling.
  task automatic send_word(input logic [7:0] w, input logic rdy, input bit gaps);
    for (int i = 7; i >= 0; i--) begin
      int g;
      g = gaps ? int'($urandom_range(0, 3)) : 0;
      repeat (g) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, rdy, 1'b0);
      step(w[i], 1'b1, 1'b0, rdy, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] w;
    serial_in   = 1'b0;
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    out_ready   = 1'b0;
    reset       = 1'b1;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("reset_vld", vld_m, 1'b0);
    check("reset_par", par_m, 8'h00);

    // T1: 1,0,1,0,0,1,0,1 -> 0xA5, then drained
    send_word(8'hA5, 1'b0, 1'b0);
    check("t1_par", par_m, 8'hA5);
    check("t1_vld", vld_m, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_drain", vld_m, 1'b0);

    // T2: 1,1,0,0,0,0,0,0 -> 0xC0 MSB-first, 0x03 LSB-first
    send_word(8'hC0, 1'b0, 1'b0);
    check("t2_msb", par_m, 8'hC0);
    check("t2_lsb", par_l, 8'h03);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // T3: 0x3C with random gaps
    send_word(8'h3C, 1'b0, 1'b1);
    check("t3_par", par_m, 8'h3C);
    check("t3_cnt", cnt_m, 4'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // T4: backpressure drop, then no-bubble replacement
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    check("t4_held", par_m, 8'h11);
    check("t4_ovf", ovf_m, 1'b1);
    w = 8'h33;
    for (int i = 7; i >= 1; i--) step(w[i], 1'b1, 1'b0, 1'b0, 1'b0);
    step(w[0], 1'b1, 1'b0, 1'b1, 1'b0);
    check("t4_par33", par_m, 8'h33);
    check("t4_nobubble", vld_m, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // T5: four bits of 0xF0, then frame_start restarts with 0x5A
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    w = 8'h5A;
    step(w[7], 1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_cnt_restart", cnt_m, 4'd1);
    for (int i = 6; i >= 0; i--) step(w[i], 1'b1, 1'b0, 1'b0, 1'b0);
    check("t5_par", par_m, 8'h5A);

    // T6: reset mid-word with a held word pending, then 0x81
    w = 8'h77;
    send_word(8'h11, 1'b0, 1'b0);
    for (int i = 7; i >= 3; i--) step(w[i], 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_vld", vld_m, 1'b0);
    check("t6_cnt", cnt_m, 4'd0);
    check("t6_ovf", ovf_m, 1'b0);
    check("t6_par", par_m, 8'h00);
    send_word(8'h81, 1'b0, 1'b0);
    check("t6_par81", par_m, 8'h81);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Random traffic against the model
    repeat (600) begin
      step(1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 63) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
